muldiv_seq: RTL

- Multi-cycle sequencer for the RV32M extension, sitting beside the single-cycle ALU in the execute stage.
- Accepts one MUL/DIV/REM operation at a time on the execute-stage operands (srca/srcb, funct3).
- Iterates one bit per cycle and holds the pipeline via a stall output until the result is ready.
- Drops an in-flight operation when the pipeline flushes on a taken branch or jump.

---
 rtl/muldiv_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: one multiply/divide bit per cycle beside the execute-stage ALU.
// Holds the pipeline through a combinational stall; a flush abandons the in-flight op.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [2:0]       op;
    logic [WIDTH-1:0] opnd;
    logic [W2-1:0]    acc;
    logic             neg;

    // operand decode for the accept cycle
    logic             is_div, a_sgn, b_sgn, sa, sb, div_zero, div_ovf, fast, neg_v, accept;
    logic [WIDTH-1:0] a_abs, b_abs, fast_q, fast_r;

    always_comb begin
        is_div   = funct3[2];
        a_sgn    = is_div ? ~funct3[0] : (funct3 == 3'd1 || funct3 == 3'd2);
        b_sgn    = is_div ? ~funct3[0] : (funct3 == 3'd1);
        sa       = a_sgn & srca[WIDTH-1];
        sb       = b_sgn & srcb[WIDTH-1];
        a_abs    = sa ? (WIDTH'(0) - srca) : srca;
        b_abs    = sb ? (WIDTH'(0) - srcb) : srcb;
        div_zero = is_div & (srcb == '0);
        div_ovf  = is_div & ~funct3[0] & (srca == {1'b1, {(WIDTH-1){1'b0}}}) & (&srcb);
        fast     = div_zero | div_ovf;
        fast_q   = div_zero ? {WIDTH{1'b1}} : {1'b1, {(WIDTH-1){1'b0}}};
        fast_r   = div_zero ? srca : '0;
        neg_v    = (is_div & funct3[1]) ? sa : (sa ^ sb);
        accept   = (state == IDLE) & start & ~flush;
    end

    // one iteration step: shift-add multiply or restoring divide on the shared accumulator
    logic [WIDTH:0]   mul_sum, rem_sh;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [W2-1:0]    mul_nx, div_nx;

    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_nx   = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = acc[W2-1:WIDTH-1];
        div_ge   = rem_sh >= {1'b0, opnd};
        div_diff = rem_sh[WIDTH-1:0] - opnd;
        div_nx   = {(div_ge ? div_diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    // sign fix-up and half selection
    logic [W2-1:0]    prod_s;
    logic [WIDTH-1:0] quo, rmd, fix_val;

    always_comb begin
        prod_s = neg ? (W2'(0) - acc) : acc;
        quo    = neg ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rmd    = neg ? (WIDTH'(0) - acc[W2-1:WIDTH]) : acc[W2-1:WIDTH];
        if (op[2])
            fix_val = op[1] ? rmd : quo;
        else
            fix_val = (op[1:0] == 2'd0) ? prod_s[WIDTH-1:0] : prod_s[W2-1:WIDTH];
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nx = fast ? FIX : CALC;
                CALC: if (cnt == CW'(WIDTH - 1)) state_nx = FIX;
                FIX:  state_nx = DONE;
                DONE: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign stall = accept | (state == CALC) | (state == FIX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nx;
            done  <= (state_nx == DONE);
            cnt   <= (state == CALC && state_nx == CALC) ? cnt + CW'(1) : '0;
            if (accept) begin
                op   <= funct3;
                neg  <= fast ? 1'b0 : neg_v;
                opnd <= is_div ? b_abs : a_abs;
                // fast path preloads the final {remainder, quotient}
                acc  <= fast ? {fast_r, fast_q}
                             : {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
            end else if (state == CALC && !flush) begin
                acc <= op[2] ? div_nx : mul_nx;
            end
            if (state == FIX && !flush)
                result <= fix_val;
        end
    end

endmodule
